// File: rtl/pix_clk_ctrl.sv
// pix_clk_ctrl: programmable pixel-clock divider with tick enable, boundary-aligned divisor reload
// and graceful run/stop sequencing. Optional statistics counters under PIX_CLK_CTRL_STATS_EN.
module pix_clk_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int MIN_DIV = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run_req,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_div_out,
  output logic             active,
`ifdef PIX_CLK_CTRL_STATS_EN
  output logic [CNT_W-1:0] cur_div,
  output logic [15:0]      tick_cnt,
  output logic [7:0]       cfg_rej_cnt
`else
  output logic [CNT_W-1:0] cur_div
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_DIV);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             err_q, err_d;
  logic             idle, wrap, apply, acc, bad, run_d;

  // Next-state: the period counter wraps on cur_div-1, and the registered tick/clock are derived
  // from the next count so they line up with the cycle that count occupies.
  always_comb begin
    idle         = state_q == IDLE;
    wrap         = !idle && cnt_q == cur_div_q - ONE;
    state_d      = idle ? (run_req ? RUN : IDLE) : run_req ? RUN : wrap ? IDLE : DRAIN;
    run_d        = state_d != IDLE;
    cnt_d        = (idle || !run_d || wrap) ? '0 : cnt_q + ONE;
    apply        = pend_valid_q && (idle || wrap);
    cur_div_d    = apply ? pend_div_q : cur_div_q;
    acc          = cfg_valid && !pend_valid_q;
    bad          = cfg_div < MIN;
    pend_valid_d = (acc && !bad) ? 1'b1 : apply ? 1'b0 : pend_valid_q;
    pend_div_d   = (acc && !bad) ? cfg_div : pend_div_q;
    err_d        = acc && bad;
    tick_d       = run_d && cnt_d == cur_div_d - ONE;
    clk_d        = run_d && cnt_d >= (cur_div_d >> 1);
  end

  // Core state registers; reset drops any in-flight period and pending divisor.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DEF;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      clk_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      clk_q        <= clk_d;
      err_q        <= err_d;
    end
  end

  assign cfg_ready   = !pend_valid_q;
  assign cfg_err     = err_q;
  assign tick        = tick_q;
  assign clk_div_out = clk_q;
  assign active      = state_q != IDLE;
  assign cur_div     = cur_div_q;

`ifdef PIX_CLK_CTRL_STATS_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  rej_cnt_q, rej_cnt_d;

  // Tick counter restarts on each run start; reject counter saturates.
  always_comb begin
    tick_cnt_d = (idle && state_d == RUN) ? 16'd0 : tick_q ? tick_cnt_q + 16'd1 : tick_cnt_q;
    rej_cnt_d  = (err_q && rej_cnt_q != 8'hFF) ? rej_cnt_q + 8'd1 : rej_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
      rej_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign tick_cnt    = tick_cnt_q;
  assign cfg_rej_cnt = rej_cnt_q;
`endif
endmodule

// File: tb/tb_pix_clk_ctrl.sv
// tb_pix_clk_ctrl: directed self-checking bench for pix_clk_ctrl
`timescale 1ns/1ps
module tb_pix_clk_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       run_req = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, tick, clk_div_out, active;
  logic [7:0] cur_div;
`ifdef PIX_CLK_CTRL_STATS_EN
  logic [15:0] tick_cnt;
  logic [7:0]  cfg_rej_cnt;
`endif
  int errors = 0;
  int checks = 0;

  pix_clk_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run_req(run_req),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .tick(tick), .clk_div_out(clk_div_out),
    .active(active),
`ifdef PIX_CLK_CTRL_STATS_EN
    .cur_div(cur_div), .tick_cnt(tick_cnt), .cfg_rej_cnt(cfg_rej_cnt)
`else
    .cur_div(cur_div)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] cv, tv;
    int first, nt, n, hi;
    step(2);
    check("rst_tick", tick, 0);
    check("rst_clk", clk_div_out, 0);
    check("rst_active", active, 0);
    check("rst_cur", cur_div, 4);
    check("rst_ready", cfg_ready, 1);
    check("rst_err", cfg_err, 0);
    sys_rst_n = 1'b1;
    run_req = 1'b1;
    step();
    first = -1; nt = 0; cv = '0; tv = '0;
    for (int i = 0; i < 100; i++) begin
      if (i < 8) begin
        cv[i] = clk_div_out;
        tv[i] = tick;
      end
      if (tick && first < 0) first = i;
      nt += int'(tick);
      step();
    end
    check("t1_clk", cv, 8'hCC);
    check("t1_tick", tv, 8'h88);
    check("t1_first", first, 3);
    check("t1_ticks", nt, 25);
    step(2);
    check("t2_ready_pre", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    check("t2_ready_low", cfg_ready, 0);
    check("t2_tick", tick, 1);
    check("t2_cur_old", cur_div, 4);
    step();
    check("t2_ready_back", cfg_ready, 1);
    check("t2_cur_new", cur_div, 6);
    cv = '0; tv = '0;
    for (int i = 0; i < 6; i++) begin
      cv[i] = clk_div_out;
      tv[i] = tick;
      step();
    end
    check("t2_clk6", cv, 8'h38);
    check("t2_tick6", tv, 8'h20);
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    check("t3_err", cfg_err, 1);
    check("t3_ready", cfg_ready, 1);
    check("t3_cur", cur_div, 6);
    step();
    check("t3_err_once", cfg_err, 0);
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    step(4);
    check("t4_cur", cur_div, 4);
    run_req = 1'b0;
    step();
    check("t4_drain_active", active, 1);
    check("t4_drain_tick", tick, 0);
    step();
    check("t4_tick", tick, 1);
    check("t4_clk", clk_div_out, 1);
    step();
    check("t4_idle_active", active, 0);
    check("t4_idle_clk", clk_div_out, 0);
    check("t4_idle_tick", tick, 0);
    run_req = 1'b1;
    step(4);
    check("t5_tick", tick, 1);
    cfg_valid = 1'b1; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    check("t5_ready", cfg_ready, 0);
    check("t5_cur_old", cur_div, 4);
    tv = '0;
    for (int i = 0; i < 4; i++) begin
      tv[i] = tick;
      step();
    end
    check("t5_old_period", tv, 8'h08);
    check("t5_cur_new", cur_div, 8);
    check("t5_ready_back", cfg_ready, 1);
    cv = '0; tv = '0;
    for (int i = 0; i < 8; i++) begin
      cv[i] = clk_div_out;
      tv[i] = tick;
      step();
    end
    check("t5_clk8", cv, 8'hF0);
    check("t5_tick8", tv, 8'h80);
    step();
    cfg_valid = 1'b1; cfg_div = 8'd10;
    step();
    cfg_valid = 1'b0;
    check("t6_pending", cfg_ready, 0);
    run_req = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_cur", cur_div, 4);
    check("t6_rst_ready", cfg_ready, 1);
    check("t6_rst_tick", tick, 0);
    check("t6_rst_active", active, 0);
    check("t6_rst_clk", clk_div_out, 0);
    step(2);
    sys_rst_n = 1'b1;
    step(3);
    check("t6_no_pend_cur", cur_div, 4);
    check("t6_ready", cfg_ready, 1);
    check("t6_tick", tick, 0);
    cfg_valid = 1'b1; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    step();
    check("t7_idle_apply", cur_div, 2);
    run_req = 1'b1;
    step();
    cv = '0; tv = '0;
    for (int i = 0; i < 4; i++) begin
      cv[i] = clk_div_out;
      tv[i] = tick;
      step();
    end
    check("t7_clk2", cv, 8'h0A);
    check("t7_tick2", tv, 8'h0A);
    cfg_valid = 1'b1; cfg_div = 8'd255;
    step();
    cfg_valid = 1'b0;
    n = 0;
    while (cur_div != 8'd255 && n < 10) begin
      step();
      n++;
    end
    check("t8_applied", cur_div, 255);
    n = 0; hi = 0;
    while (!tick && n < 300) begin
      hi += int'(clk_div_out);
      step();
      n++;
    end
    hi += int'(clk_div_out);
    check("t8_len", n, 254);
    check("t8_high", hi, 128);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pix_clk_ctrl.md
Name: pix_clk_ctrl

Overview:
Programmable pixel-clock scheduler for the display path. Generates a divided clock and a one-cycle tick enable from sys_clk. The divisor is reconfigured at runtime through a valid/ready handshake, and the new divisor takes effect only on a period boundary, so no runt pulses occur. Run and stop sequencing are graceful. Downstream timing logic consumes tick or clk_div_out.

Parameters:
CNT_W, 8, width of divisor and period counter
DEF_DIV, 4, divisor after reset (100 MHz -> 25 MHz)
MIN_DIV, 2, smallest legal divisor; smaller requests are rejected

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst_n  in  1  asynchronous active-low reset
run_req  in  1  level; 1 = run the divider, 0 = stop at end of current period
cfg_valid  in  1  divisor update request
cfg_div  in  CNT_W  requested divisor, in sys_clk cycles per output period
cfg_ready  out  1  combinational; equals !pend_valid
cfg_err  out  1  one-cycle pulse when an accepted request has cfg_div < MIN_DIV
tick  out  1  one-cycle pulse on the last sys_clk cycle of each period
clk_div_out  out  1  registered divided clock
active  out  1  1 in RUN or DRAIN
cur_div  out  CNT_W  divisor currently in use

Behaviour:
- Reset (asynchronous, sys_rst_n=0): state=IDLE, cnt=0, cur_div=DEF_DIV, pend_valid=0, tick=0, clk_div_out=0, cfg_err=0, active=0.
- States:
  - IDLE: cnt held at 0, outputs low. run_req=1 -> RUN; the first period starts with cnt=0 on the next cycle.
  - RUN: cnt increments each cycle. When cnt==cur_div-1, tick=1 and cnt wraps to 0 on the next cycle. run_req=0 -> DRAIN without truncating the period.
  - DRAIN: counts as in RUN. On the tick cycle -> IDLE; clk_div_out=0 and cnt=0 from the next cycle. run_req=1 while in DRAIN -> RUN with no gap.
- tick and clk_div_out are registered. A period is cur_div cycles long.
- clk_div_out is 0 for cnt < cur_div>>1 and 1 otherwise. For an odd divisor the high phase is the longer one. Example, div=4: pattern 0,0,1,1 with tick on the 4th cycle. Period 40 ns; tick rate 25 MHz.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - If cfg_div < MIN_DIV: nothing is stored and cfg_err pulses on the following cycle.
  - Otherwise pend_div <= cfg_div and pend_valid <= 1.
- Apply:
  - In IDLE, pending is applied on the next cycle.
  - In RUN or DRAIN, pending is applied on the tick cycle: cur_div <= pend_div and pend_valid <= 0, so the next period uses the new divisor.
- Simultaneous events:
  - A request accepted on a tick cycle is not yet pending, so it applies at the following boundary.
  - A pending apply and a DRAIN -> IDLE exit on the same tick both occur.
  - cfg_ready stays low until the apply completes. Requesters hold cfg_valid until ready.
- Boundary conditions:
  - cnt compare is done at full CNT_W width. cur_div = 2^CNT_W-1 is legal.
  - cnt never exceeds cur_div-1.
  - Reset mid-period discards the period and any pending config.

Optional Feature:
Macro PIX_CLK_CTRL_STATS_EN.
- Defined: adds output tick_cnt [15:0], a count of tick pulses. It is cleared by reset and on every IDLE -> RUN transition, and wraps from 0xFFFF to 0. It also adds output cfg_rej_cnt [7:0], a count of cfg_err pulses that saturates at 0xFF.
- Not defined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
1. Reset, then run_req=1 with DEF_DIV=4 -> clk_div_out 0,0,1,1 repeating. tick every 4th cycle; first tick on the 4th cycle after RUN entry; 25 ticks in 1 us.
2. In RUN, send cfg_div=6 mid-period -> cfg_ready drops for one cycle. The current 4-cycle period completes. The next period is 6 cycles (0,0,0,1,1,1). cur_div=6 after the boundary.
3. Send cfg_div=1 -> cfg_err pulses once, cur_div unchanged, cfg_ready stays 1.
4. Drop run_req at cnt=1 with div=4 -> two more cycles, tick, then IDLE. active goes low the cycle after the tick; clk_div_out=0.
5. Accept cfg_div=8 on a tick cycle -> the next period still uses the old divisor; the period after uses 8.
6. Assert sys_rst_n=0 mid-period with cfg_div=10 pending -> immediate reset. After release, cur_div=4, cfg_ready=1, tick=0.
